score_collector: RTL and testbench



---
 rtl/score_collector_pkg.sv | 10 +
 rtl/score_slot_reg.sv | 17 +
 rtl/score_collector.sv | 115 +++++++++++
 tb/tb_score_collector.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_collector_pkg.sv
// Shared constants for the class-score collector feeding the argmax comparator.
package score_collector_pkg;
    localparam int NUM_CLASSES         = 10;
    localparam int IDX_W               = 4;
    localparam int DATAIN_SIZE_DEFAULT = 25;

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
endpackage

// File: rtl/score_slot_reg.sv
// One class-score slot: load-enabled register with synchronous clear.
module score_slot_reg #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/score_collector.sv
// Collects ten serial class scores into parallel registered buses, pulses en
// once per complete frame, then holds the buses before re-arming.
module score_collector
    import score_collector_pkg::*;
#(
    parameter int DATAIN_SIZE = DATAIN_SIZE_DEFAULT,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATAIN_SIZE-1:0] score_in,
    input  logic                   score_valid,
    input  logic                   score_last,
    output logic                   score_ready,
    output logic [DATAIN_SIZE-1:0] dataout0,
    output logic [DATAIN_SIZE-1:0] dataout1,
    output logic [DATAIN_SIZE-1:0] dataout2,
    output logic [DATAIN_SIZE-1:0] dataout3,
    output logic [DATAIN_SIZE-1:0] dataout4,
    output logic [DATAIN_SIZE-1:0] dataout5,
    output logic [DATAIN_SIZE-1:0] dataout6,
    output logic [DATAIN_SIZE-1:0] dataout7,
    output logic [DATAIN_SIZE-1:0] dataout8,
    output logic [DATAIN_SIZE-1:0] dataout9,
    output logic                   en,
    output logic                   frame_err
);
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    logic [1:0]                                state;
    logic [IDX_W-1:0]                          idx;
    logic [CNT_W-1:0]                          hold_cnt;
    logic [NUM_CLASSES-1:0]                    slot_ld;
    logic [NUM_CLASSES-1:0][DATAIN_SIZE-1:0]   slot_q;
    logic                                      accept;
    logic                                      at_last_slot;

    // Ready is forced low while rst is asserted so nothing is accepted in the reset cycle.
    assign score_ready  = (state == ST_FILL) && !rst;
    assign accept       = score_valid && score_ready;
    assign at_last_slot = (idx == IDX_W'(NUM_CLASSES - 1));

    always_comb begin
        slot_ld = '0;
        for (int i = 0; i < NUM_CLASSES; i++)
            slot_ld[i] = accept && (idx == IDX_W'(i));
    end

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_slot
        score_slot_reg #(.W(DATAIN_SIZE)) u_slot (
            .clk (clk),
            .clr (rst),
            .ld  (slot_ld[g]),
            .d   (score_in),
            .q   (slot_q[g])
        );
    end

    assign dataout0 = slot_q[0];
    assign dataout1 = slot_q[1];
    assign dataout2 = slot_q[2];
    assign dataout3 = slot_q[3];
    assign dataout4 = slot_q[4];
    assign dataout5 = slot_q[5];
    assign dataout6 = slot_q[6];
    assign dataout7 = slot_q[7];
    assign dataout8 = slot_q[8];
    assign dataout9 = slot_q[9];

    // en is registered on the completing accept, so it is high exactly in PRESENT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            idx       <= '0;
            hold_cnt  <= '0;
            en        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            en        <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (at_last_slot && score_last) begin
                            state <= ST_PRESENT;
                            idx   <= '0;
                            en    <= 1'b1;
                        end else if (at_last_slot || score_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_PRESENT: begin
                    state    <= ST_HOLD;
                    hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= ST_FILL;
                        idx   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                    idx   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_score_collector.sv
// Bench for score_collector: two instances (hold 1 and hold 3) on shared stimulus,
// checked every cycle against a frame-level model plus directed literal checks.
module tb_score_collector;
    localparam int W      = 25;
    localparam int NC     = 10;
    localparam int HOLD_A = 1;
    localparam int HOLD_B = 3;
    localparam logic [W-1:0] MAXV = 25'h1FFFFFF;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   score_in = '0;
    logic           score_valid = 1'b0;
    logic           score_last = 1'b0;
    logic [1:0]     rdy, en, ferr;
    logic [1:0][NC-1:0][W-1:0] dout;

    always #5 clk = ~clk;

    score_collector #(.DATAIN_SIZE(W), .HOLD_CYCLES(HOLD_A)) u_a (
        .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
        .score_last(score_last), .score_ready(rdy[0]),
        .dataout0(dout[0][0]), .dataout1(dout[0][1]), .dataout2(dout[0][2]),
        .dataout3(dout[0][3]), .dataout4(dout[0][4]), .dataout5(dout[0][5]),
        .dataout6(dout[0][6]), .dataout7(dout[0][7]), .dataout8(dout[0][8]),
        .dataout9(dout[0][9]), .en(en[0]), .frame_err(ferr[0])
    );

    score_collector #(.DATAIN_SIZE(W), .HOLD_CYCLES(HOLD_B)) u_b (
        .clk(clk), .rst(rst), .score_in(score_in), .score_valid(score_valid),
        .score_last(score_last), .score_ready(rdy[1]),
        .dataout0(dout[1][0]), .dataout1(dout[1][1]), .dataout2(dout[1][2]),
        .dataout3(dout[1][3]), .dataout4(dout[1][4]), .dataout5(dout[1][5]),
        .dataout6(dout[1][6]), .dataout7(dout[1][7]), .dataout8(dout[1][8]),
        .dataout9(dout[1][9]), .en(en[1]), .frame_err(ferr[1])
    );

    int           checks = 0;
    int           failures = 0;
    bit           chk_on = 0;
    int           m_cnt [2];
    int           m_blk [2];
    logic [W-1:0] m_out [2][NC];
    logic         m_en  [2];
    logic         m_err [2];
    int           en_seen [2];
    int           err_seen [2];

    task automatic chk(string nm, int k, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures < 40)
                $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", nm, k, got, exp, $time);
        end
    endtask

    // Frame-level model: m_blk counts the cycles the collector refuses input after a frame.
    task automatic model_step(int k, int h);
        m_en[k]  = 1'b0;
        m_err[k] = 1'b0;
        if (rst) begin
            m_cnt[k] = 0;
            m_blk[k] = 0;
            for (int i = 0; i < NC; i++) m_out[k][i] = '0;
        end else if (m_blk[k] > 0) begin
            m_blk[k]--;
        end else if (score_valid) begin
            m_out[k][m_cnt[k]] = score_in;
            if (m_cnt[k] == NC-1 && score_last) begin
                m_en[k] = 1'b1;  m_blk[k] = h + 1;  m_cnt[k] = 0;
            end else if (m_cnt[k] == NC-1 || score_last) begin
                m_err[k] = 1'b1; m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_blk[k] = 0; en_seen[k] = 0; err_seen[k] = 0;
        end
        forever begin
            @(posedge clk);
            model_step(0, HOLD_A);
            model_step(1, HOLD_B);
            @(negedge clk);
            if (chk_on) begin
                for (int k = 0; k < 2; k++) begin
                    chk("score_ready", k, W'(rdy[k]), W'(!rst && m_blk[k] == 0));
                    chk("en", k, W'(en[k]), W'(m_en[k]));
                    chk("frame_err", k, W'(ferr[k]), W'(m_err[k]));
                    for (int i = 0; i < NC; i++)
                        chk($sformatf("dataout%0d", i), k, dout[k][i], m_out[k][i]);
                    en_seen[k]  += int'(en[k]);
                    err_seen[k] += int'(ferr[k]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(int k, logic [W-1:0] v, logic l, int gap);
        int guard = 0;
        score_in = v; score_valid = 1'b1; score_last = l;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL send_timeout dut=%0d got=ready_low exp=ready_high", k);
        end
        step();
        score_valid = 1'b0; score_last = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, f0;
        rst = 1'b1;
        step(); step();
        chk_on = 1;
        chk("reset_ready", 0, W'(rdy[0]), '0);
        chk("reset_en", 0, W'(en[0]), '0);
        chk("reset_dataout3", 0, dout[0][3], '0);
        rst = 1'b0;

        // back-to-back frame 10..100
        for (int i = 0; i < NC; i++) send(0, W'((i + 1) * 10), i == NC-1, 0);
        chk("s1_en_after_10th", 0, W'(en[0]), W'(1));
        chk("s1_ready_present", 0, W'(rdy[0]), '0);
        step();
        chk("s1_en_one_cycle", 0, W'(en[0]), '0);
        chk("s1_ready_hold", 0, W'(rdy[0]), '0);
        step();
        chk("s1_ready_rearm", 0, W'(rdy[0]), W'(1));
        chk("s1_dataout0", 0, dout[0][0], W'(10));
        chk("s1_dataout4", 0, dout[0][4], W'(50));
        chk("s1_dataout9", 0, dout[0][9], W'(100));

        // same frame with valid toggling
        e0 = en_seen[0]; f0 = err_seen[0];
        for (int i = 0; i < NC; i++) send(0, W'((i + 1) * 10), i == NC-1, (i == NC-1) ? 0 : 1);
        chk("s2_en_after_10th", 0, W'(en[0]), W'(1));
        step();
        chk("s2_en_count", 0, W'(en_seen[0] - e0), W'(1));
        chk("s2_no_err", 0, W'(err_seen[0] - f0), '0);
        chk("s2_dataout9", 0, dout[0][9], W'(100));

        // early last on the 4th score, then a good frame 1..10
        e0 = en_seen[0]; f0 = err_seen[0];
        for (int i = 0; i < 4; i++) send(0, W'(i + 1), i == 3, 0);
        chk("s3_err_pulse", 0, W'(ferr[0]), W'(1));
        chk("s3_no_en", 0, W'(en[0]), '0);
        for (int i = 0; i < NC; i++) send(0, W'(i + 1), i == NC-1, 0);
        chk("s3_en", 0, W'(en[0]), W'(1));
        chk("s3_dataout9", 0, dout[0][9], W'(10));
        step();
        chk("s3_err_count", 0, W'(err_seen[0] - f0), W'(1));
        chk("s3_en_count", 0, W'(en_seen[0] - e0), W'(1));

        // missing last on the 10th, then a good frame ending in max value
        for (int i = 0; i < NC; i++) send(0, (i == NC-1) ? MAXV : W'(i + 1), 1'b0, 0);
        chk("s4_err_pulse", 0, W'(ferr[0]), W'(1));
        chk("s4_no_en", 0, W'(en[0]), '0);
        chk("s4_slot9_written", 0, dout[0][9], MAXV);
        for (int i = 0; i < NC; i++) send(0, (i == NC-1) ? MAXV : W'(i + 11), i == NC-1, 0);
        chk("s4_en", 0, W'(en[0]), W'(1));
        chk("s4_dataout0", 0, dout[0][0], W'(11));
        chk("s4_dataout9", 0, dout[0][9], MAXV);
        step(); step();

        // reset after 6 accepts, then a fresh frame
        for (int i = 0; i < 6; i++) send(0, W'(100 + i), 1'b0, 0);
        chk("s5_partial5", 0, dout[0][5], W'(105));
        rst = 1'b1;
        step();
        chk("s5_rst_dataout0", 0, dout[0][0], '0);
        chk("s5_rst_dataout5", 0, dout[0][5], '0);
        chk("s5_rst_en", 0, W'(en[0]), '0);
        chk("s5_rst_ready", 0, W'(rdy[0]), '0);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) send(0, W'(300 + i), i == NC-1, 0);
        chk("s5_en", 0, W'(en[0]), W'(1));
        chk("s5_dataout9", 0, dout[0][9], W'(309));

        // hold of 3 with upstream pushing new data during PRESENT/HOLD
        do_reset();
        for (int i = 0; i < NC; i++) send(1, W'(200 + i), i == NC-1, 0);
        chk("s6_en", 1, W'(en[1]), W'(1));
        score_in = W'(12'hABC); score_valid = 1'b1; score_last = 1'b0;
        for (int c = 0; c < HOLD_B + 1; c++) begin
            chk("s6_ready_low", 1, W'(rdy[1]), '0);
            chk("s6_hold_dataout0", 1, dout[1][0], W'(200));
            chk("s6_hold_dataout9", 1, dout[1][9], W'(209));
            step();
        end
        chk("s6_ready_rearm", 1, W'(rdy[1]), W'(1));
        step();
        score_valid = 1'b0;
        chk("s6_first_held", 1, dout[1][0], W'(12'hABC));
        chk("s6_slot1_kept", 1, dout[1][1], W'(201));

        // randomized traffic, mostly well-formed frames with occasional faults and resets
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            score_valid = ($urandom_range(9) < 7);
            score_in    = W'($urandom());
            if (m_cnt[0] == NC-1)
                score_last = score_valid && ($urandom_range(7) != 0);
            else
                score_last = score_valid && ($urandom_range(19) == 0);
            rst = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0; score_valid = 1'b0; score_last = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
